// File: rtl/cia_tod_primitives_pkg.sv
// Shared CIA types: the TOD register image and its per-digit field layout.
// The tod_t fields are ordered hr_hi down to tenths, so tenths is at the least-significant end.
package cia;

  typedef logic [3:0] reg4_t;
  typedef logic [7:0] reg8_t;

  typedef struct packed {
    logic [0:0] hr_hi;
    logic [3:0] hr_lo;
    logic [2:0] min_hi;
    logic [3:0] min_lo;
    logic [2:0] sec_hi;
    logic [3:0] sec_lo;
    logic [3:0] tenths;
  } tod_t;

  localparam int TOD_W    = $bits(tod_t);
  localparam int TOD_DIGS = 7;

endpackage

// File: rtl/cia_tod_primitives_bcd_update.sv
// Combinational BCD digit stage. A load has priority over counting.
// A digit above MAX counts up and wraps to 0 without producing a carry.
module bcd_update #(
  parameter  int MAX = 9,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic         we,
  input  logic [W-1:0] data,
  input  logic [W-1:0] cur,
  input  logic         cin,
  output logic [W-1:0] next,
  output logic         cout
);

  // next-digit and carry selection
  always_comb begin
    next = cur;
    cout = 1'b0;
    if (we) begin
      next = data;
    end else if (cin) begin
      if (cur == W'(MAX)) begin
        next = '0;
        cout = 1'b1;
      end else begin
        next = cur + W'(1);
      end
    end else begin
      next = cur;
    end
  end

endmodule

// File: rtl/cia_tod_primitives_negedge.sv
// Falling-edge detector for pad inputs, sampled only on the PHI2-falling strobe.
module cia_negedge (
  input  logic clk,
  input  logic res,
  input  logic phi2_dn,
  input  logic signal,
  output logic trigger
);

  logic r_prev;
  logic r_trigger;

  // Because the last sample clears to 0, a low level present at reset release does not trigger.
  always_ff @(posedge clk) begin
    if (res) begin
      r_prev    <= 1'b0;
      r_trigger <= 1'b0;
    end else if (phi2_dn) begin
      r_trigger <= r_prev & ~signal;
      r_prev    <= signal;
    end else begin
      r_prev    <= r_prev;
      r_trigger <= r_trigger;
    end
  end

  assign trigger = r_trigger;

endmodule

// File: rtl/cia_tod_primitives.sv
// Primitive slice: three standalone digit stages (MAX 9/5/1), the full
// seven-stage TOD carry chain, and one falling-edge detector.
module cia_tod_primitives
  import cia::*;
(
  input  logic                clk,
  input  logic                res,
  input  logic                i_d9_we,
  input  logic [3:0]          i_d9_data,
  input  logic [3:0]          i_d9_cur,
  input  logic                i_d9_cin,
  output logic [3:0]          o_d9_next,
  output logic                o_d9_cout,
  input  logic                i_d5_we,
  input  logic [2:0]          i_d5_data,
  input  logic [2:0]          i_d5_cur,
  input  logic                i_d5_cin,
  output logic [2:0]          o_d5_next,
  output logic                o_d5_cout,
  input  logic                i_d1_we,
  input  logic                i_d1_data,
  input  logic                i_d1_cur,
  input  logic                i_d1_cin,
  output logic                o_d1_next,
  output logic                o_d1_cout,
  input  logic                i_tod_we,
  input  logic [TOD_W-1:0]    i_tod_data,
  input  logic [TOD_W-1:0]    i_tod_cur,
  input  logic                i_tod_cin,
  output logic [TOD_W-1:0]    o_tod_next,
  output logic [TOD_DIGS-1:0] o_tod_cout,
  input  logic                i_phi2_dn,
  input  logic                i_signal,
  output logic                o_trigger
);

  tod_t                w_data;
  tod_t                w_cur;
  tod_t                w_next;
  logic [TOD_DIGS-1:0] w_carry;

  assign w_data     = tod_t'(i_tod_data);
  assign w_cur      = tod_t'(i_tod_cur);
  assign o_tod_next = w_next;
  assign o_tod_cout = w_carry;

  bcd_update #(.MAX(9)) u_d9 (.we(i_d9_we), .data(i_d9_data), .cur(i_d9_cur),
    .cin(i_d9_cin), .next(o_d9_next), .cout(o_d9_cout));
  bcd_update #(.MAX(5)) u_d5 (.we(i_d5_we), .data(i_d5_data), .cur(i_d5_cur),
    .cin(i_d5_cin), .next(o_d5_next), .cout(o_d5_cout));
  bcd_update #(.MAX(1)) u_d1 (.we(i_d1_we), .data(i_d1_data), .cur(i_d1_cur),
    .cin(i_d1_cin), .next(o_d1_next), .cout(o_d1_cout));

  // The carry ripples from tenths up to hr_hi. The 12 -> 01 hour fixup is done outside this block.
  bcd_update #(.MAX(9)) u_tenths (.we(i_tod_we), .data(w_data.tenths), .cur(w_cur.tenths),
    .cin(i_tod_cin),  .next(w_next.tenths), .cout(w_carry[0]));
  bcd_update #(.MAX(9)) u_sec_lo (.we(i_tod_we), .data(w_data.sec_lo), .cur(w_cur.sec_lo),
    .cin(w_carry[0]), .next(w_next.sec_lo), .cout(w_carry[1]));
  bcd_update #(.MAX(5)) u_sec_hi (.we(i_tod_we), .data(w_data.sec_hi), .cur(w_cur.sec_hi),
    .cin(w_carry[1]), .next(w_next.sec_hi), .cout(w_carry[2]));
  bcd_update #(.MAX(9)) u_min_lo (.we(i_tod_we), .data(w_data.min_lo), .cur(w_cur.min_lo),
    .cin(w_carry[2]), .next(w_next.min_lo), .cout(w_carry[3]));
  bcd_update #(.MAX(5)) u_min_hi (.we(i_tod_we), .data(w_data.min_hi), .cur(w_cur.min_hi),
    .cin(w_carry[3]), .next(w_next.min_hi), .cout(w_carry[4]));
  bcd_update #(.MAX(9)) u_hr_lo  (.we(i_tod_we), .data(w_data.hr_lo),  .cur(w_cur.hr_lo),
    .cin(w_carry[4]), .next(w_next.hr_lo),  .cout(w_carry[5]));
  bcd_update #(.MAX(1)) u_hr_hi  (.we(i_tod_we), .data(w_data.hr_hi),  .cur(w_cur.hr_hi),
    .cin(w_carry[5]), .next(w_next.hr_hi),  .cout(w_carry[6]));

  cia_negedge u_negedge (
    .clk     (clk),
    .res     (res),
    .phi2_dn (i_phi2_dn),
    .signal  (i_signal),
    .trigger (o_trigger)
  );

endmodule

// File: tb/tb_cia_tod_primitives.sv
// Directed self-checking bench for the BCD digit stages, the TOD chain and the edge detector.
module tb_cia_tod_primitives;

  logic        clk = 1'b0;
  logic        res;
  logic        i_d9_we, i_d9_cin, o_d9_cout;
  logic [3:0]  i_d9_data, i_d9_cur, o_d9_next;
  logic        i_d5_we, i_d5_cin, o_d5_cout;
  logic [2:0]  i_d5_data, i_d5_cur, o_d5_next;
  logic        i_d1_we, i_d1_data, i_d1_cur, i_d1_cin, o_d1_next, o_d1_cout;
  logic        i_tod_we, i_tod_cin;
  logic [22:0] i_tod_data, i_tod_cur, o_tod_next;
  logic [6:0]  o_tod_cout;
  logic        i_phi2_dn, i_signal, o_trigger;

  int n_tests = 0;
  int n_fail  = 0;
  int ph      = 0;

  always #5 clk = ~clk;

  cia_tod_primitives dut (
    .clk(clk), .res(res),
    .i_d9_we(i_d9_we), .i_d9_data(i_d9_data), .i_d9_cur(i_d9_cur), .i_d9_cin(i_d9_cin),
    .o_d9_next(o_d9_next), .o_d9_cout(o_d9_cout),
    .i_d5_we(i_d5_we), .i_d5_data(i_d5_data), .i_d5_cur(i_d5_cur), .i_d5_cin(i_d5_cin),
    .o_d5_next(o_d5_next), .o_d5_cout(o_d5_cout),
    .i_d1_we(i_d1_we), .i_d1_data(i_d1_data), .i_d1_cur(i_d1_cur), .i_d1_cin(i_d1_cin),
    .o_d1_next(o_d1_next), .o_d1_cout(o_d1_cout),
    .i_tod_we(i_tod_we), .i_tod_data(i_tod_data), .i_tod_cur(i_tod_cur), .i_tod_cin(i_tod_cin),
    .o_tod_next(o_tod_next), .o_tod_cout(o_tod_cout),
    .i_phi2_dn(i_phi2_dn), .i_signal(i_signal), .o_trigger(o_trigger)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clk; the strobe is high on every fourth cycle (ph == 0).
  task automatic tick();
    i_phi2_dn = (ph == 0);
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4;
  endtask

  // One strobe period: sig[i] is driven for clk i (i = 0 is the strobe); trigger is checked against exp[i].
  task automatic run_period(input string tag, input logic [3:0] sig, input logic [3:0] exp);
    for (int i = 0; i < 4; i++) begin
      i_signal = sig[i];
      tick();
      check_eq($sformatf("%s_clk%0d", tag, i), {31'd0, o_trigger}, {31'd0, exp[i]});
    end
  endtask

  initial begin
    logic [3:0]  e_next;
    logic        e_cout;
    logic [22:0] e_tod;
    res = 1'b1; i_phi2_dn = 1'b0; i_signal = 1'b1;
    i_d9_we = 1'b0; i_d9_data = 4'd0; i_d9_cur = 4'd0; i_d9_cin = 1'b0;
    i_d5_we = 1'b0; i_d5_data = 3'd0; i_d5_cur = 3'd0; i_d5_cin = 1'b0;
    i_d1_we = 1'b0; i_d1_data = 1'b0; i_d1_cur = 1'b0; i_d1_cin = 1'b0;
    i_tod_we = 1'b0; i_tod_data = 23'd0; i_tod_cur = 23'd0; i_tod_cin = 1'b0;

    // MAX = 9 stage, exhaustive over cur/cin/we
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 2; c++) begin
        for (int v = 0; v < 16; v++) begin
          i_d9_we = w[0]; i_d9_cin = c[0]; i_d9_cur = v[3:0]; i_d9_data = 4'(15 - v);
          #1;
          if (w == 1)          begin e_next = 4'(15 - v); e_cout = 1'b0; end
          else if (c == 0)     begin e_next = v[3:0];     e_cout = 1'b0; end
          else if (v == 9)     begin e_next = 4'd0;       e_cout = 1'b1; end
          else                 begin e_next = 4'(v + 1);  e_cout = 1'b0; end
          check_eq($sformatf("d9_next_we%0d_cin%0d_cur%0d", w, c, v), {28'd0, o_d9_next}, {28'd0, e_next});
          check_eq($sformatf("d9_cout_we%0d_cin%0d_cur%0d", w, c, v), {31'd0, o_d9_cout}, {31'd0, e_cout});
        end
      end
    end
    i_d9_we = 1'b1; i_d9_data = 4'd7; i_d9_cur = 4'd3; i_d9_cin = 1'b1; #1;
    check_eq("d9_load7_next", {28'd0, o_d9_next}, 32'd7);
    check_eq("d9_load7_cout", {31'd0, o_d9_cout}, 32'd0);
    i_d9_we = 1'b0; i_d9_cur = 4'd15; #1;
    check_eq("d9_f_wrap_next", {28'd0, o_d9_next}, 32'd0);
    check_eq("d9_f_wrap_cout", {31'd0, o_d9_cout}, 32'd0);

    i_d5_cin = 1'b1; i_d5_cur = 3'd5; #1;
    check_eq("d5_max_next", {29'd0, o_d5_next}, 32'd0);
    check_eq("d5_max_cout", {31'd0, o_d5_cout}, 32'd1);
    i_d5_cur = 3'd2; #1;
    check_eq("d5_inc_next", {29'd0, o_d5_next}, 32'd3);
    check_eq("d5_inc_cout", {31'd0, o_d5_cout}, 32'd0);
    i_d1_cin = 1'b1; i_d1_cur = 1'b1; #1;
    check_eq("d1_max_next", {31'd0, o_d1_next}, 32'd0);
    check_eq("d1_max_cout", {31'd0, o_d1_cout}, 32'd1);
    i_d1_cur = 1'b0; #1;
    check_eq("d1_inc_next", {31'd0, o_d1_next}, 32'd1);
    check_eq("d1_inc_cout", {31'd0, o_d1_cout}, 32'd0);

    // TOD chain: 12:59:59.9 + 1 -> 13:00:00.0 before the external hour fixup
    i_tod_cur = {1'b1, 4'd2, 3'd5, 4'd9, 3'd5, 4'd9, 4'd9}; i_tod_cin = 1'b1; #1;
    e_tod = {1'b1, 4'd3, 3'd0, 4'd0, 3'd0, 4'd0, 4'd0};
    check_eq("tod_roll_next", {9'd0, o_tod_next}, {9'd0, e_tod});
    check_eq("tod_roll_cout", {25'd0, o_tod_cout}, {25'd0, 7'b0011111});
    i_tod_cur = {1'b0, 4'd4, 3'd3, 4'd2, 3'd1, 4'd0, 4'd5}; #1;
    e_tod = {1'b0, 4'd4, 3'd3, 4'd2, 3'd1, 4'd0, 4'd6};
    check_eq("tod_inc_next", {9'd0, o_tod_next}, {9'd0, e_tod});
    check_eq("tod_inc_cout", {25'd0, o_tod_cout}, 32'd0);
    i_tod_we = 1'b1; i_tod_data = {1'b1, 4'd1, 3'd4, 4'd5, 3'd2, 4'd8, 4'd3}; #1;
    e_tod = {1'b1, 4'd1, 3'd4, 4'd5, 3'd2, 4'd8, 4'd3};
    check_eq("tod_load_next", {9'd0, o_tod_next}, {9'd0, e_tod});
    check_eq("tod_load_cout", {25'd0, o_tod_cout}, 32'd0);

    // Edge detector
    ph = 0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("neg_reset", {31'd0, o_trigger}, 32'd0);
    res = 1'b0;
    run_period("p1_high",      4'b1111, 4'b0000);
    run_period("p2_fall_mid",  4'b0011, 4'b0000);
    run_period("p3_fall_seen", 4'b0000, 4'b1111);
    run_period("p4_rise_mid",  4'b1100, 4'b0000);
    run_period("p5_rise",      4'b1111, 4'b0000);
    run_period("p6_glitch",    4'b1001, 4'b0000);
    run_period("p7_after_gl",  4'b1111, 4'b0000);
    run_period("p8_fall",      4'b0000, 4'b1111);
    run_period("p9_rise",      4'b1111, 4'b0000);
    run_period("p10_fall",     4'b0000, 4'b1111);
    run_period("p11_rise",     4'b1111, 4'b0000);

    // Reset while trigger is high, then hold signal low through reset release
    i_signal = 1'b0;
    tick();
    check_eq("p12_trig_before_res", {31'd0, o_trigger}, 32'd1);
    res = 1'b1;
    tick();
    check_eq("p12_res_clears", {31'd0, o_trigger}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check_eq("p12_res_hold", {31'd0, o_trigger}, 32'd0);
    res = 1'b0;
    run_period("p13_low_at_release", 4'b0000, 4'b0000);
    run_period("p14_low_hold",       4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
